// File: rtl/alu_exec_stage_pkg.sv
// Shared ALU definitions: control codes, default datapath width, decode helper.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package alu_exec_stage_pkg;

  // Default operand/result width of the execute datapath.
  localparam int ALU_WIDTH = 32;

  // ALU control codes, shared with the ALU control decoder upstream.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // True when the code names one of the implemented operations.
  function automatic logic alu_op_legal(input logic [3:0] op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
           (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Operation in / result out handshake bundle of the ALU execute stage.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the operation and the result side.
interface alu_exec_stage_if
  import alu_exec_stage_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  // Operation side (from the ALU control decoder / register read).
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALU_Control;
  logic [WIDTH-1:0] Op_A;
  logic [WIDTH-1:0] Op_B;

  // Result side (to writeback / branch unit).
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Overflow;
  logic             Illegal;

  // Producer of operations and consumer of results.
  modport master (
    output in_valid, ALU_Control, Op_A, Op_B, out_ready,
    input  in_ready, out_valid, Result, Zero, Overflow, Illegal
  );

  // The execute stage itself.
  modport slave (
    input  in_valid, ALU_Control, Op_A, Op_B, out_ready,
    output in_ready, out_valid, Result, Zero, Overflow, Illegal
  );

endinterface

// File: rtl/alu_exec_stage_alu_core.sv
// Combinational ALU: AND/OR/ADD/SUB/SLT with zero, signed-overflow and illegal-code flags.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when the outputs are captured.
module alu_core
  import alu_exec_stage_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             sign_a;
  logic             sign_b;

  assign sum    = op_a + op_b;
  assign diff   = op_a - op_b;
  assign sign_a = op_a[WIDTH-1];
  assign sign_b = op_b[WIDTH-1];

  // Select the result and signed overflow for the requested operation; unknown codes yield 0.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_control)
      ALU_AND: result = op_a & op_b;
      ALU_OR:  result = op_a | op_b;
      ALU_ADD: begin
        result   = sum;
        overflow = (sign_a == sign_b) && (sum[WIDTH-1] != sign_a);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (sign_a != sign_b) && (diff[WIDTH-1] != sign_a);
      end
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: result = '0;
    endcase
  end

  // Zero looks at the final result, so SUB of equal operands drives the BEQ path.
  assign zero    = (result == '0);
  assign illegal = !alu_op_legal(alu_control);

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a 2-entry result queue behind the combinational ALU.
// Latency: 1 cycle from accept to out_valid when the queue is empty.
// Backpressure: in_ready drops only when both entries are full; it never looks at out_ready.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_exec_stage_if.slave  bus
);

  // One queued ALU outcome.
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;
  } entry_t;

  // The queue is built for exactly two entries; DEPTH only sets the full threshold.
  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_overflow;
  logic             core_illegal;
  entry_t           core_entry;
  entry_t           head_entry;
  entry_t           q_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .alu_control (bus.ALU_Control),
    .op_a        (bus.Op_A),
    .op_b        (bus.Op_B),
    .result      (core_result),
    .zero        (core_zero),
    .overflow    (core_overflow),
    .illegal     (core_illegal)
  );

  assign core_entry = '{result:   core_result,
                        zero:     core_zero,
                        overflow: core_overflow,
                        illegal:  core_illegal};

  // Ready and valid come straight from the occupancy register: no in-to-out combinational path.
  assign bus.in_ready  = (count != FULL_COUNT);
  assign bus.out_valid = (count != 2'd0);

  assign push = bus.in_valid  && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: the ALU outcome is captured into the tail slot on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_mem[0] <= '0;
      q_mem[1] <= '0;
    end else if (push) begin
      q_mem[wr_ptr] <= core_entry;
    end
  end

  // Outputs show the head entry, forced to zero while the queue is empty (including during reset).
  assign head_entry   = bus.out_valid ? q_mem[rd_ptr] : '0;
  assign bus.Result   = head_entry.result;
  assign bus.Zero     = head_entry.zero;
  assign bus.Overflow = head_entry.overflow;
  assign bus.Illegal  = head_entry.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage.
// Inputs change on the falling edge; outputs are sampled on the falling edge before changing.
module tb_alu_exec_stage;
  import alu_exec_stage_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  alu_exec_stage_if #(.WIDTH(32)) bus ();

  alu_exec_stage #(
    .WIDTH (32),
    .DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid    = 1'b1;
    bus.ALU_Control = ctrl;
    bus.Op_A        = a;
    bus.Op_B        = b;
  endtask

  // Issue one op into an empty queue with out_ready=1; head must appear next cycle for one cycle.
  task automatic run_one(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_z,
                         input logic exp_ov, input logic exp_il);
    bus.out_ready = 1'b1;
    drive_op(ctrl, a, b);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_val({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    check_val({tag, ".Result"},    bus.Result,           exp_res);
    check_val({tag, ".Zero"},      32'(bus.Zero),        32'(exp_z));
    check_val({tag, ".Overflow"},  32'(bus.Overflow),    32'(exp_ov));
    check_val({tag, ".Illegal"},   32'(bus.Illegal),     32'(exp_il));
    @(negedge clk);
    check_val({tag, ".drained"},   32'(bus.out_valid),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks        = 0;
    n_fails         = 0;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.ALU_Control = 4'b0000;
    bus.Op_A        = '0;
    bus.Op_B        = '0;
    bus.out_ready   = 1'b0;

    // Reset state.
    @(negedge clk);
    check_val("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst.in_ready",  32'(bus.in_ready),  32'd1);
    check_val("rst.Result",    bus.Result,         32'd0);
    check_val("rst.Zero",      32'(bus.Zero),      32'd0);
    check_val("rst.Overflow",  32'(bus.Overflow),  32'd0);
    check_val("rst.Illegal",   32'(bus.Illegal),   32'd0);
    rst_n = 1'b1;

    // Single operations through an empty queue.
    run_one("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_one("sub_eq",  ALU_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    run_one("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_one("illegal", 4'b0101, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_one("and",     ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0, 1'b0);
    run_one("sub_ovf", ALU_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_one("slt_pos", ALU_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);

    // Back-pressure: fill both entries, hold the third op at the source.
    bus.out_ready = 1'b0;
    drive_op(ALU_OR, 32'd1, 32'd2);
    @(negedge clk);
    check_val("bp.in_ready_1", 32'(bus.in_ready), 32'd1);
    check_val("bp.head_1",     bus.Result,        32'd3);
    drive_op(ALU_ADD, 32'd2, 32'd2);
    @(negedge clk);
    check_val("bp.in_ready_2", 32'(bus.in_ready), 32'd0);
    check_val("bp.head_2",     bus.Result,        32'd3);
    drive_op(ALU_SUB, 32'd9, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("bp.full_hold", 32'(bus.in_ready),  32'd0);
      check_val("bp.head_hold", bus.Result,         32'd3);
      check_val("bp.valid",     32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_val("bp.drain_4",    bus.Result,        32'd4);
    check_val("bp.in_ready_3", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_val("bp.drain_8",    bus.Result,         32'd8);
    check_val("bp.valid_8",    32'(bus.out_valid), 32'd1);
    @(negedge clk);
    check_val("bp.empty",      32'(bus.out_valid), 32'd0);

    // Steady state at one entry: one result per cycle across pointer wrap.
    bus.out_ready = 1'b0;
    drive_op(ALU_ADD, 32'd0, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check_val("ss.valid",    32'(bus.out_valid), 32'd1);
      check_val("ss.in_ready", 32'(bus.in_ready),  32'd1);
      check_val("ss.Result",   bus.Result,         32'(2 * i));
      if (i < 9) begin
        drive_op(ALU_ADD, 32'(i + 1), 32'(i + 1));
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
    check_val("ss.empty", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset with a full queue.
    bus.out_ready = 1'b0;
    drive_op(ALU_ADD, 32'd5, 32'd5);
    @(negedge clk);
    drive_op(ALU_ADD, 32'd6, 32'd6);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_val("ar.full",       32'(bus.in_ready),  32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_val("ar.out_valid",  32'(bus.out_valid), 32'd0);
    check_val("ar.in_ready",   32'(bus.in_ready),  32'd1);
    check_val("ar.Result",     bus.Result,         32'd0);
    check_val("ar.Zero",       32'(bus.Zero),      32'd0);
    check_val("ar.Overflow",   32'(bus.Overflow),  32'd0);
    check_val("ar.Illegal",    32'(bus.Illegal),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_one("ar.add", ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_val("ar.no_stale", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
